// File: rtl/param_sa_cache.sv
// N-way set-associative, write-back, write-allocate L1 cache with tree pseudo-LRU replacement,
// invalid-way-first allocation, a lockout hold for misses and a side-effect-free peek probe.
module param_sa_cache #(
   parameter int ADDR_W = 16,
   parameter int WORD_W = 16,
   parameter int LINE_W = 128,
   parameter int SETS   = 8,
   parameter int WAYS   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   mem_address,
   input  logic [WORD_W-1:0]   mem_wdata,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [WORD_W/8-1:0] mem_byte_enable,
   output logic [WORD_W-1:0]   mem_rdata,
   output logic                mem_resp,
   input  logic [LINE_W-1:0]   pmem_rdata,
   input  logic                pmem_resp,
   output logic [ADDR_W-1:0]   pmem_address,
   output logic [LINE_W-1:0]   pmem_wdata,
   output logic                pmem_read,
   output logic                pmem_write,
   input  logic                lockout,
   input  logic [ADDR_W-1:0]   peek_address,
   output logic                peek_hit
);

   localparam int BE_W   = WORD_W / 8;
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int WAY_W  = $clog2(WAYS);
   localparam int BOFF_W = $clog2(BE_W);
   localparam int WSEL_W = OFF_W - BOFF_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

   state_t                        state_q, state_d;
   logic [SETS-1:0][WAYS-1:0]     valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0]     dirty_q, dirty_d;
   logic [SETS-1:0][WAYS-2:0]     plru_q, plru_d;
   logic [TAG_W-1:0]              tag_q  [SETS][WAYS];
   logic [TAG_W-1:0]              tag_d  [SETS][WAYS];
   logic [LINE_W-1:0]             data_q [SETS][WAYS];
   logic [LINE_W-1:0]             data_d [SETS][WAYS];
   logic [WAY_W-1:0]              victim_q, victim_d;
   logic [TAG_W-1:0]              req_tag_q, req_tag_d;
   logic [IDX_W-1:0]              req_idx_q, req_idx_d;
   logic                          pmem_read_q, pmem_read_d;
   logic                          pmem_write_q, pmem_write_d;
   logic [ADDR_W-1:0]             pmem_address_q, pmem_address_d;
   logic [LINE_W-1:0]             pmem_wdata_q, pmem_wdata_d;

   logic                          req;
   logic [IDX_W-1:0]              idx;
   logic [TAG_W-1:0]              tag;
   logic [WSEL_W-1:0]             wsel;
   logic                          hit;
   logic [WAY_W-1:0]              hit_way;
   logic                          any_invalid;
   logic [WAY_W-1:0]              inv_way;
   logic [WAY_W-1:0]              victim_sel;
   logic [LINE_W-1:0]             hit_line;
   logic [LINE_W-1:0]             merged_line;
   logic [IDX_W-1:0]              peek_idx;
   logic [TAG_W-1:0]              peek_tag;
   logic                          unused_lsbs;

   // Each tree node bit names the child subtree that holds the next victim (0 = lower ways).
   function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
      logic ok;
      plru_victim = '0;
      for (int v = 0; v < WAYS; v++) begin
         ok = 1'b1;
         for (int l = 0; l < WAY_W; l++)
            if (t[(1 << l) + (v >> (WAY_W - l)) - 1] != v[WAY_W-1-l]) ok = 1'b0;
         if (ok) plru_victim = WAY_W'(v);
      end
   endfunction

   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                  input logic [WAY_W-1:0] w);
      plru_touch = t;
      for (int l = 0; l < WAY_W; l++)
         plru_touch[(1 << l) + (int'(w) >> (WAY_W - l)) - 1] = ~w[WAY_W-1-l];
   endfunction

   assign req         = mem_read | mem_write;
   assign idx         = mem_address[OFF_W +: IDX_W];
   assign tag         = mem_address[OFF_W+IDX_W +: TAG_W];
   assign wsel        = mem_address[BOFF_W +: WSEL_W];
   assign peek_idx    = peek_address[OFF_W +: IDX_W];
   assign peek_tag    = peek_address[OFF_W+IDX_W +: TAG_W];
   assign unused_lsbs = ^{mem_address[0], peek_address[OFF_W-1:0]};

   always_comb begin
      hit         = 1'b0;
      hit_way     = '0;
      any_invalid = 1'b0;
      inv_way     = '0;
      peek_hit    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!any_invalid && !valid_q[idx][w]) begin
            any_invalid = 1'b1;
            inv_way     = WAY_W'(w);
         end
         if (valid_q[peek_idx][w] && tag_q[peek_idx][w] == peek_tag) peek_hit = 1'b1;
      end
      victim_sel  = any_invalid ? inv_way : plru_victim(plru_q[idx]);
      hit_line    = data_q[idx][hit_way];
      merged_line = hit_line;
      for (int b = 0; b < BE_W; b++)
         if (mem_byte_enable[b])
            merged_line[int'(wsel)*WORD_W + b*8 +: 8] = mem_wdata[b*8 +: 8];
   end

   assign mem_resp  = (state_q == IDLE) && req && hit;
   assign mem_rdata = mem_resp ? hit_line[int'(wsel)*WORD_W +: WORD_W] : '0;

   // Hits are served in IDLE; a miss latches its victim and request line so the pmem sequence
   // completes and installs the line even if the CPU withdraws the request.
   always_comb begin
      state_d        = state_q;
      valid_d        = valid_q;
      dirty_d        = dirty_q;
      plru_d         = plru_q;
      tag_d          = tag_q;
      data_d         = data_q;
      victim_d       = victim_q;
      req_tag_d      = req_tag_q;
      req_idx_d      = req_idx_q;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               plru_d[idx] = plru_touch(plru_q[idx], hit_way);
               if (mem_write) begin
                  data_d[idx][hit_way]  = merged_line;
                  dirty_d[idx][hit_way] = 1'b1;
               end
            end else if (req && !lockout) begin
               victim_d  = victim_sel;
               req_tag_d = tag;
               req_idx_d = idx;
               if (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) begin
                  state_d        = WRITEBACK;
                  pmem_write_d   = 1'b1;
                  pmem_address_d = {tag_q[idx][victim_sel], idx, {OFF_W{1'b0}}};
                  pmem_wdata_d   = data_q[idx][victim_sel];
               end else begin
                  state_d        = ALLOCATE;
                  pmem_read_d    = 1'b1;
                  pmem_address_d = {tag, idx, {OFF_W{1'b0}}};
               end
            end
         end
         WRITEBACK: begin
            if (pmem_resp) begin
               state_d        = ALLOCATE;
               pmem_write_d   = 1'b0;
               pmem_read_d    = 1'b1;
               pmem_address_d = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            end
         end
         ALLOCATE: begin
            if (pmem_resp) begin
               state_d                        = IDLE;
               pmem_read_d                    = 1'b0;
               pmem_address_d                 = '0;
               data_d[req_idx_q][victim_q]    = pmem_rdata;
               tag_d[req_idx_q][victim_q]     = req_tag_q;
               valid_d[req_idx_q][victim_q]   = 1'b1;
               dirty_d[req_idx_q][victim_q]   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         valid_q        <= '0;
         dirty_q        <= '0;
         plru_q         <= '0;
         victim_q       <= '0;
         req_tag_q      <= '0;
         req_idx_q      <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         valid_q        <= valid_d;
         dirty_q        <= dirty_d;
         plru_q         <= plru_d;
         victim_q       <= victim_d;
         req_tag_q      <= req_tag_d;
         req_idx_q      <= req_idx_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
      end
   end

   // Line data and tags are qualified by valid bits, so they carry no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;

endmodule
